// File: rtl/alu_arbiter_pkg.sv
// Types and constants shared by alu_arbiter and its alu_4_bits datapath.
package alu_arbiter_pkg;
`include "alu_defs.vh"

  localparam int ALU_W = 4;

  localparam logic [1:0] M_ADD = `ALU_M_ADD;
  localparam logic [1:0] M_SUB = `ALU_M_SUB;
  localparam logic [1:0] M_AND = `ALU_M_AND;
  localparam logic [1:0] M_XOR = `ALU_M_XOR;

  typedef enum logic [1:0] {
    IDLE = `ALU_ST_IDLE,
    EXEC = `ALU_ST_EXEC,
    RESP = `ALU_ST_RESP
  } state_t;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             cin;
    logic [1:0]       m;
  } alu_op_t;

  function automatic alu_op_t pick_op(input logic sel, input alu_op_t op0, input alu_op_t op1);
    return sel ? op1 : op0;
  endfunction

endpackage

// File: rtl/alu_4_bits.sv
// 4-bit ALU: ADD (a+b+cin), SUB (a+~b+cin, cout = no-borrow), AND, XOR.
module alu_4_bits
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  input  logic             i_cin,
  input  logic [1:0]       i_m,
  output logic [ALU_W-1:0] o_f,
  output logic             o_cout
);

  logic [ALU_W:0] w_sum;
  logic [ALU_W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b}  + {{ALU_W{1'b0}}, i_cin};
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{ALU_W{1'b0}}, i_cin};

  always_comb begin
    o_f    = w_sum[ALU_W-1:0];
    o_cout = w_sum[ALU_W];
    case (i_m)
      M_ADD: begin
        o_f    = w_sum[ALU_W-1:0];
        o_cout = w_sum[ALU_W];
      end
      M_SUB: begin
        o_f    = w_diff[ALU_W-1:0];
        o_cout = w_diff[ALU_W];
      end
      M_AND: begin
        o_f    = i_a & i_b;
        o_cout = 1'b0;
      end
      M_XOR: begin
        o_f    = i_a ^ i_b;
        o_cout = 1'b0;
      end
      default: begin
        o_f    = '0;
        o_cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_defs.vh
// Shared ALU mode and FSM state encodings for the arbitrated ALU.
`ifndef ALU_DEFS_VH
`define ALU_DEFS_VH

`define ALU_M_ADD   2'b00
`define ALU_M_SUB   2'b01
`define ALU_M_AND   2'b10
`define ALU_M_XOR   2'b11

`define ALU_ST_IDLE 2'b00
`define ALU_ST_EXEC 2'b01
`define ALU_ST_RESP 2'b10

`endif

// File: rtl/alu_arbiter.sv
// Two requesters share one alu_4_bits through an IDLE/EXEC/RESP handshake FSM.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int OP_COUNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [ALU_W-1:0]      req0_a,
  input  logic [ALU_W-1:0]      req0_b,
  input  logic                  req0_cin,
  input  logic [1:0]            req0_m,
  input  logic [ALU_W-1:0]      req1_a,
  input  logic [ALU_W-1:0]      req1_b,
  input  logic                  req1_cin,
  input  logic [1:0]            req1_m,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [ALU_W-1:0]      rsp_f,
  output logic                  rsp_cout,
  output logic                  busy,
  output logic [OP_COUNT_W-1:0] op_count
);

  state_t                r_state;
  state_t                w_state_nxt;
  alu_op_t               r_op;
  logic                  r_id;
  logic [ALU_W-1:0]      r_f;
  logic                  r_cout;
  logic [OP_COUNT_W-1:0] r_cnt;

  alu_op_t               w_op0;
  alu_op_t               w_op1;
  logic                  w_any;
  logic                  w_gnt_id;
  logic                  w_accept;
  logic                  w_done;
  logic [ALU_W-1:0]      w_alu_f;
  logic                  w_alu_cout;

  assign w_op0 = {req0_a, req0_b, req0_cin, req0_m};
  assign w_op1 = {req1_a, req1_b, req1_cin, req1_m};
  assign w_any = |req_valid;

`ifdef ALU_ARB_RR_EN
  // r_last holds the id of the most recent grant; reset to 1 so requester 0 wins first.
  logic r_last;

  assign w_gnt_id = (&req_valid) ? ~r_last : ~req_valid[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_gnt_id;
    end
  end
`else
  assign w_gnt_id = ~req_valid[0];
`endif

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && !rst) begin
          w_accept    = 1'b1;
          req_ready   = w_gnt_id ? 2'b10 : 2'b01;
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_id    <= 1'b0;
      r_f     <= '0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op <= pick_op(w_gnt_id, w_op0, w_op1);
        r_id <= w_gnt_id;
      end
      if (r_state == EXEC) begin
        r_f    <= w_alu_f;
        r_cout <= w_alu_cout;
      end
      if (w_done) begin
        r_cnt <= r_cnt + OP_COUNT_W'(1);
      end
    end
  end

  // The shared ALU only ever sees the latched operands, never the live request buses.
  alu_4_bits u_alu (
    .i_a    (r_op.a),
    .i_b    (r_op.b),
    .i_cin  (r_op.cin),
    .i_m    (r_op.m),
    .o_f    (w_alu_f),
    .o_cout (w_alu_cout)
  );

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_id    = r_id;
  assign rsp_f     = r_f;
  assign rsp_cout  = r_cout;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, scoreboard monitor, reset/backpressure/contention sequences.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_cin, req1_cin;
  logic [1:0] req0_m, req1_m;
  logic       rsp_ready;

  logic [1:0] req_ready;
  logic       rsp_valid, rsp_id, rsp_cout, busy;
  logic [3:0] rsp_f;
  logic [7:0] op_count;

  logic [1:0] w_req_ready;
  logic       w_rsp_valid, w_rsp_id, w_rsp_cout, w_busy;
  logic [3:0] w_rsp_f;
  logic [1:0] w_op_count;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;
  int exp_cnt = 0;

  typedef struct {
    logic [1:0] rv;
    logic [3:0] a0, b0; logic c0; logic [1:0] m0;
    logic [3:0] a1, b1; logic c1; logic [1:0] m1;
    logic [1:0] exp_rdy;
    logic       exp_id;
    logic [3:0] exp_f;
    logic       exp_cout;
  } vec_t;

  typedef struct {
    logic       id;
    logic [3:0] f;
    logic       cout;
  } sb_t;

  sb_t  exp_q[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_m(req0_m),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_m(req1_m),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_f(rsp_f), .rsp_cout(rsp_cout), .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.OP_COUNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w_req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_m(req0_m),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_m(req1_m),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w_rsp_id),
    .rsp_f(w_rsp_f), .rsp_cout(w_rsp_cout), .busy(w_busy), .op_count(w_op_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic set_ops(input logic [3:0] a0, b0, input logic c0, input logic [1:0] m0,
                         input logic [3:0] a1, b1, input logic c1, input logic [1:0] m1);
    req0_a = a0; req0_b = b0; req0_cin = c0; req0_m = m0;
    req1_a = a1; req1_b = b1; req1_cin = c1; req1_m = m1;
  endtask

  // Monitor: samples mid low-phase; a handshake seen here completes at the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      chk("op_count", {24'd0, op_count}, exp_cnt & 32'hFF);
      chk("op_count_w2", {30'd0, w_op_count}, exp_cnt & 32'h3);
      if (rst) begin
        exp_q.delete();
        exp_cnt = 0;
      end else if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_pop: response id=%0d f=%0h with nothing expected", rsp_id, rsp_f);
        end else begin
          sb_t e;
          e = exp_q.pop_front();
          chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          chk("rsp_f", {28'd0, rsp_f}, {28'd0, e.f});
          chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, e.cout});
          chk("rsp_f_w2", {28'd0, w_rsp_f}, {28'd0, e.f});
          exp_cnt++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b01, 4'h7, 4'h1, 1'b1, 2'b00, 4'hA, 4'h5, 1'b0, 2'b11, 2'b01, 1'b0, 4'h9, 1'b0};
    tbl[1] = '{2'b10, 4'h3, 4'h3, 1'b1, 2'b00, 4'hF, 4'h1, 1'b0, 2'b00, 2'b10, 1'b1, 4'h0, 1'b1};
    tbl[2] = '{2'b01, 4'h9, 4'h3, 1'b1, 2'b01, 4'h1, 4'h1, 1'b0, 2'b00, 2'b01, 1'b0, 4'h6, 1'b1};
    tbl[3] = '{2'b10, 4'hE, 4'hE, 1'b0, 2'b10, 4'h3, 4'h9, 1'b1, 2'b01, 2'b10, 1'b1, 4'hA, 1'b0};
    tbl[4] = '{2'b01, 4'hC, 4'hA, 1'b0, 2'b10, 4'h2, 4'h2, 1'b1, 2'b00, 2'b01, 1'b0, 4'h8, 1'b0};
    tbl[5] = '{2'b10, 4'hF, 4'h0, 1'b0, 2'b00, 4'hC, 4'hA, 1'b1, 2'b11, 2'b10, 1'b1, 4'h6, 1'b0};
    tbl[6] = '{2'b01, 4'hF, 4'hF, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0, 2'b10, 2'b01, 1'b0, 4'hF, 1'b1};
    tbl[7] = '{2'b10, 4'h8, 4'h8, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 2'b00, 2'b10, 1'b1, 4'h0, 1'b0};

    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    set_ops(4'h0, 4'h0, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    #1 chk("rst_req_ready", {30'd0, req_ready}, 32'd0);

    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_f", {28'd0, rsp_f}, 32'd0);
    chk("rst_rsp_cout", {31'd0, rsp_cout}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_op_count", {24'd0, op_count}, 32'd0);
    mon_en = 1'b1;

    // Reset while in EXEC discards the operation.
    set_ops(4'h7, 4'h1, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0, 2'b00);
    req_valid = 2'b01;
    #1 chk("midrst_ready", {30'd0, req_ready}, 32'h1);
    @(negedge clk);
    #1 chk("midrst_busy_exec", {31'd0, busy}, 32'd1);
    req_valid = 2'b00; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset in RESP overrides a same-cycle handshake.
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("resprst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("resprst_rsp_f", {28'd0, rsp_f}, 32'h9);
    rst = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("resprst_busy", {31'd0, busy}, 32'd0);
    chk("resprst_rsp_valid0", {31'd0, rsp_valid}, 32'd0);
    chk("resprst_rsp_f0", {28'd0, rsp_f}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      set_ops(tbl[i].a0, tbl[i].b0, tbl[i].c0, tbl[i].m0, tbl[i].a1, tbl[i].b1, tbl[i].c1, tbl[i].m1);
      req_valid = tbl[i].rv;
      #1;
      chk($sformatf("v%0d_ready", i), {30'd0, req_ready}, {30'd0, tbl[i].exp_rdy});
      chk($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
      exp_q.push_back('{tbl[i].exp_id, tbl[i].exp_f, tbl[i].exp_cout});
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_exec_ready", i), {30'd0, req_ready}, 32'd0);
      chk($sformatf("v%0d_exec_busy", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("v%0d_resp_ready", i), {30'd0, req_ready}, 32'd0);
      req_valid = 2'b00;
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_back_idle", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_rsp_valid0", i), {31'd0, rsp_valid}, 32'd0);
    end

    // Backpressure: five cycles held in RESP with both requesters knocking.
    rsp_ready = 1'b0;
    set_ops(4'h5, 4'h6, 1'b0, 2'b00, 4'h9, 4'h9, 1'b1, 2'b00);
    req_valid = 2'b01;
    #1 chk("bp_ready", {30'd0, req_ready}, 32'h1);
    exp_q.push_back('{1'b0, 4'hB, 1'b0});
    @(negedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_f", {28'd0, rsp_f}, 32'hB);
      chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_idle", {31'd0, busy}, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);

    // Contention from a fresh reset with both requesters always valid.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_ops(4'h1, 4'h2, 1'b0, 2'b00, 4'h4, 4'h8, 1'b0, 2'b00);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic gid;
`ifdef ALU_ARB_RR_EN
      gid = (k % 2 == 1);
`else
      gid = 1'b0;
`endif
      #1 chk($sformatf("cont%0d_ready", k), {30'd0, req_ready}, gid ? 32'h2 : 32'h1);
      exp_q.push_back('{gid, gid ? 4'hC : 4'h3, 1'b0});
      repeat (3) @(negedge clk);
    end
    #1;
    chk("cont_op_count", {24'd0, op_count}, 32'd4);
    chk("cont_op_count_w2", {30'd0, w_op_count}, 32'd0);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    #1 chk("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter OP_COUNT_W, default 8, width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  2  bit i = requester i presents an operation.
REQ-005 req_ready  output  2  bit i = requester i accepted this cycle (one-hot or zero).
REQ-006 req0_a, req0_b  input  4 each  requester 0 operands.
REQ-007 req0_cin  input  1; req0_m  input  2  requester 0 carry-in and ALU mode.
REQ-008 req1_a, req1_b, req1_cin, req1_m  input  4/4/1/2  requester 1 equivalents.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_id  output  1  requester that owns the result.
REQ-012 rsp_f  output  4; rsp_cout  output  1  registered ALU result and carry-out.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 op_count  output  OP_COUNT_W  number of completed response handshakes.

Function
REQ-015 Block SHALL share one alu_4_bits instance between two requesters; ALU inputs driven only from internal operand registers.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP.
REQ-017 IDLE: if any req_valid, assert req_ready for exactly the granted requester (combinational, same cycle), latch its a/b/cin/m and id at the edge, go EXEC; else stay.
REQ-018 req_ready SHALL be 0 in EXEC and RESP.
REQ-019 EXEC: one cycle; at the edge capture ALU f/cout into rsp_f/rsp_cout, go RESP.
REQ-020 RESP: rsp_valid=1; rsp_f, rsp_cout, rsp_id held stable until the edge where rsp_ready=1, then go IDLE and increment op_count.
REQ-021 Latency: acceptance at edge N gives rsp_valid high in the cycle after edge N+1; minimum 3 cycles per operation.
REQ-022 op_count SHALL wrap from all-ones to 0 without saturating.
REQ-023 req_valid changes while not in IDLE SHALL be ignored; requests are not queued.
REQ-024 rsp_ready while rsp_valid=0 SHALL have no effect.

Reset
REQ-025 rst SHALL force IDLE, req_ready=0, rsp_valid=0, rsp_f=0, rsp_cout=0, rsp_id=0, op_count=0, operand registers=0, last-grant register=1.
REQ-026 rst asserted in EXEC or RESP SHALL discard the operation without incrementing op_count; rst overrides any same-cycle handshake.

Configuration
REQ-027 Macro ALU_ARB_RR_EN defined: round-robin; when both valid in IDLE, grant the requester not granted last; single requester always granted; last-grant updated on each acceptance.
REQ-028 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins; last-grant register not built.

Structure
REQ-029 Shared include header alu_defs.vh (with include guard) SHALL hold ALU mode constants (2'b00 = ADD, f = a+b+cin) and FSM state encodings.
REQ-030 alu_4_bits SHALL be the only sub-module, instantiated once; arbitration and FSM stay in alu_arbiter.

Verification
REQ-031 Single op: req_valid=01, req0 a=0111 b=0001 cin=1 m=00 -> req_ready=01 same cycle, rsp_valid two cycles later, rsp_f=1001, rsp_cout=0, rsp_id=0.
REQ-032 Contention (RR_EN defined): both valid continuously after reset, rsp_ready=1 -> grants 0,1,0,1; rsp_id alternates; op_count=4 after four ops.
REQ-033 Contention (RR_EN undefined): both valid continuously -> every grant to 0, req1 starved, rsp_id always 0.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_f stable, req_ready=00, busy=1; rsp_ready=1 -> IDLE next cycle, op_count+1.
REQ-035 Reset mid-op: rst in EXEC -> next cycle IDLE, rsp_valid=0, op_count unchanged.
REQ-036 Wrap: OP_COUNT_W=2, five completed ops -> op_count sequence 1,2,3,0,1.
